// File: rtl/node_info_pkg.sv
// Shared packet-type codes, phase encoding and saturating add for the EER-RL node state block.
package node_info_pkg;

    localparam logic [2:0] PKT_HB    = 3'b000;
    localparam logic [2:0] PKT_CH    = 3'b001;
    localparam logic [2:0] PKT_SCHED = 3'b100;
    localparam logic [2:0] PKT_DATA  = 3'b101;

    typedef enum logic [1:0] {
        PH_IDLE      = 2'd0,
        PH_LOCKED    = 2'd1,
        PH_CLUSTERED = 2'd2,
        PH_SCHEDULED = 2'd3
    } phase_e;

    // Unsigned a+b clamped to the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/node_info_if.sv
// Packet-filter to node-info bus: one strobe plus the decoded packet fields.
interface node_info_if #(
    parameter int WORD_W = 16,
    parameter int PKT_W  = 3
);
    logic              en_MNI;
    logic [PKT_W-1:0]  fPktType;
    logic [WORD_W-1:0] e_max;
    logic [WORD_W-1:0] e_min;
    logic [WORD_W-1:0] e_threshold;
    logic [WORD_W-1:0] hops;
    logic [WORD_W-1:0] ch_ID;
    logic [WORD_W-1:0] timeslot;

    modport master (output en_MNI, fPktType, e_max, e_min, e_threshold, hops, ch_ID, timeslot);
    modport slave  (input  en_MNI, fPktType, e_max, e_min, e_threshold, hops, ch_ID, timeslot);
endinterface

// File: rtl/node_info_ctrl_tdma.sv
// TDMA slot timer: cycle/slot counters and a registered own-slot transmit enable.
module tdma_slot_timer #(
    parameter int SLOT_CYCLES = 64,
    parameter int NUM_SLOTS   = 16,
    parameter int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              restart,
    input  logic [SLOT_W-1:0] slot,
    output logic              tx_en
);
    localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;

    always_comb begin
        cyc_d      = '0;
        slot_idx_d = '0;
        if (run && !restart) begin
            if (cyc_q == CYC_W'(SLOT_CYCLES - 1)) begin
                cyc_d      = '0;
                slot_idx_d = (slot_idx_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : SLOT_W'(slot_idx_q + SLOT_W'(1));
            end else begin
                cyc_d      = CYC_W'(cyc_q + CYC_W'(1));
                slot_idx_d = slot_idx_q;
            end
        end
    end

    // tx_en is computed from next-cycle counter values so it lines up with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q      <= '0;
            slot_idx_q <= '0;
            tx_en      <= 1'b0;
        end else begin
            cyc_q      <= cyc_d;
            slot_idx_q <= slot_idx_d;
            tx_en      <= run && (slot_idx_d == slot);
        end
    end
endmodule

// File: rtl/node_info_ctrl.sv
// EER-RL per-node state: HB/CH/SCHED latching, phase FSM with lock timeout, TDMA window.
// Optional build macro NODE_INFO_HYST_EN enables the low-energy hysteresis.
module node_info_ctrl
    import node_info_pkg::*;
#(
    parameter int                WORD_W       = 16,
    parameter int                PKT_W        = 3,
    parameter logic [WORD_W-1:0] NODE_ID      = 16'h000C,
    parameter int                LOCK_TIMEOUT = 1024,
    parameter int                SLOT_CYCLES  = 64,
    parameter int                NUM_SLOTS    = 16,
    parameter logic [WORD_W-1:0] E_HYST       = 16'd32
) (
    input  logic              clk,
    input  logic              rst,
    node_info_if.slave        pkt,
    input  logic [WORD_W-1:0] energy,
    input  logic [WORD_W-1:0] q_in,
    input  logic              q_valid,
    output logic [WORD_W-1:0] myNodeID,
    output logic [WORD_W-1:0] hopsFromSink,
    output logic [WORD_W-1:0] myQValue,
    output logic [WORD_W-1:0] eMax,
    output logic [WORD_W-1:0] eMin,
    output logic [WORD_W-1:0] eThr,
    output logic              role,
    output logic              low_E,
    output logic [1:0]        phase,
    output logic              tx_en
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT);

    phase_e            phase_q, phase_d, pkt_d;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              is_hb, is_ch, is_sc, is_dt, in_lock;
    logic              latch_fields, take_hops, set_role, sched_ld, low_d;
    logic              unused_ts_hi;

    assign myNodeID     = NODE_ID;
    assign phase        = phase_q;
    assign unused_ts_hi = ^pkt.timeslot[WORD_W-1:SLOT_W];

    always_comb begin
        is_hb        = pkt.en_MNI && (pkt.fPktType == PKT_W'(PKT_HB));
        is_ch        = pkt.en_MNI && (pkt.fPktType == PKT_W'(PKT_CH));
        is_sc        = pkt.en_MNI && (pkt.fPktType == PKT_W'(PKT_SCHED));
        is_dt        = pkt.en_MNI && (pkt.fPktType == PKT_W'(PKT_DATA));
        in_lock      = (phase_q == PH_LOCKED) || (phase_q == PH_CLUSTERED);
        latch_fields = is_hb && (phase_q == PH_IDLE);
        take_hops    = latch_fields || (is_hb && in_lock && (pkt.hops < hopsFromSink));
        set_role     = is_ch && in_lock;
        sched_ld     = is_sc && ((phase_q == PH_CLUSTERED) || (phase_q == PH_SCHEDULED));
        slot_d       = sched_ld ? pkt.timeslot[SLOT_W-1:0] : slot_q;

        pkt_d = phase_q;
        case (phase_q)
            PH_IDLE:      if (is_hb) pkt_d = PH_LOCKED;
            PH_LOCKED:    if (is_ch) pkt_d = PH_CLUSTERED;
            PH_CLUSTERED: if (is_sc) pkt_d = PH_SCHEDULED;
            default:      pkt_d = phase_q;
        endcase
        if (is_dt) pkt_d = PH_IDLE;

        // A packet that moves the FSM this cycle takes priority over the timeout.
        phase_d = pkt_d;
        if (in_lock && (pkt_d == phase_q) && (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)))
            phase_d = PH_IDLE;
    end

    always_comb begin
        low_d = low_E;
`ifdef NODE_INFO_HYST_EN
        if (energy < eThr)
            low_d = 1'b1;
        else if (energy >= WORD_W'(sat_add(32'(eThr), 32'(E_HYST), WORD_W)))
            low_d = 1'b0;
`else
        low_d = (energy < eThr);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= PH_IDLE;
            tmo_cnt      <= '0;
            hopsFromSink <= '0;
            eMax         <= '0;
            eMin         <= '0;
            eThr         <= '0;
            role         <= 1'b0;
            slot_q       <= '0;
            myQValue     <= '0;
            low_E        <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (phase_d != phase_q || !in_lock)
                tmo_cnt <= '0;
            else
                tmo_cnt <= TMO_W'(tmo_cnt + TMO_W'(1));
            if (take_hops) hopsFromSink <= pkt.hops;
            if (latch_fields) begin
                eMax <= pkt.e_max;
                eMin <= pkt.e_min;
                eThr <= pkt.e_threshold;
            end
            if (set_role) role <= (pkt.ch_ID == NODE_ID);
            slot_q <= slot_d;
            if (q_valid) myQValue <= q_in;
            low_E <= low_d;
        end
    end

    tdma_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .NUM_SLOTS   (NUM_SLOTS),
        .SLOT_W      (SLOT_W)
    ) u_tdma (
        .clk     (clk),
        .rst     (rst),
        .run     (phase_d == PH_SCHEDULED),
        .restart (sched_ld),
        .slot    (slot_d),
        .tx_en   (tx_en)
    );
endmodule

// File: tb/tb_node_info_ctrl.sv
// Scoreboard bench for node_info_ctrl: a behavioural model pushes expected outputs each cycle.
module tb_node_info_ctrl;
    localparam int LT = 8;
    localparam int SC = 4;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] energy, q_in;
    logic        q_valid;
    logic [15:0] myNodeID, hopsFromSink, myQValue, eMax, eMin, eThr;
    logic        role, low_E, tx_en;
    logic [1:0]  phase;

    always #5 clk = ~clk;

    node_info_if #(.WORD_W(16), .PKT_W(3)) pkt_if ();

    node_info_ctrl #(
        .WORD_W(16), .PKT_W(3), .NODE_ID(16'h000C), .LOCK_TIMEOUT(LT),
        .SLOT_CYCLES(SC), .NUM_SLOTS(NS), .E_HYST(16'd32)
    ) dut (
        .clk(clk), .rst(rst), .pkt(pkt_if.slave), .energy(energy), .q_in(q_in),
        .q_valid(q_valid), .myNodeID(myNodeID), .hopsFromSink(hopsFromSink),
        .myQValue(myQValue), .eMax(eMax), .eMin(eMin), .eThr(eThr), .role(role),
        .low_E(low_E), .phase(phase), .tx_en(tx_en)
    );

    typedef struct {
        int phase; int hops; int q; int emax; int emin; int ethr;
        int role; int lowe; int tx;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    // model state
    int m_phase, m_hops, m_q, m_emax, m_emin, m_ethr, m_role, m_lowe, m_tx;
    int m_ts, m_cnt, m_k;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  np, thr_hi, e, t;
        bit  hb, ch, sc, dt, ld;
        exp_t x;
        if (rst) begin
            m_phase = 0; m_hops = 0; m_q = 0; m_emax = 0; m_emin = 0; m_ethr = 0;
            m_role = 0; m_lowe = 0; m_tx = 0; m_ts = 0; m_cnt = 0; m_k = 0;
        end else begin
            t  = int'(pkt_if.fPktType);
            hb = pkt_if.en_MNI && t == 0;
            ch = pkt_if.en_MNI && t == 1;
            sc = pkt_if.en_MNI && t == 4;
            dt = pkt_if.en_MNI && t == 5;
            e  = int'(energy);
            thr_hi = m_ethr + 32;
            if (thr_hi > 65535) thr_hi = 65535;
`ifdef NODE_INFO_HYST_EN
            if (e < m_ethr) m_lowe = 1;
            else if (e >= thr_hi) m_lowe = 0;
`else
            m_lowe = (e < m_ethr) ? 1 : 0;
`endif
            if (q_valid) m_q = int'(q_in);
            np = m_phase;
            ld = 0;
            if (m_phase == 0 && hb) begin
                np = 1; m_hops = int'(pkt_if.hops); m_emax = int'(pkt_if.e_max);
                m_emin = int'(pkt_if.e_min); m_ethr = int'(pkt_if.e_threshold);
            end
            if ((m_phase == 1 || m_phase == 2) && hb && int'(pkt_if.hops) < m_hops)
                m_hops = int'(pkt_if.hops);
            if ((m_phase == 1 || m_phase == 2) && ch) begin
                m_role = (pkt_if.ch_ID == 16'h000C) ? 1 : 0;
                if (m_phase == 1) np = 2;
            end
            if ((m_phase == 2 || m_phase == 3) && sc) begin
                np = 3; ld = 1; m_ts = int'(pkt_if.timeslot);
            end
            if (dt) np = 0;
            if ((m_phase == 1 || m_phase == 2) && np == m_phase && m_cnt == LT - 1) np = 0;
            if (np != m_phase || !(m_phase == 1 || m_phase == 2)) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            if (ld) m_k = 0;
            else if (np == 3) m_k = m_k + 1;
            m_tx = (np == 3 && ((m_k / SC) % NS) == (m_ts % NS)) ? 1 : 0;
            m_phase = np;
        end
        x.phase = m_phase; x.hops = m_hops; x.q = m_q; x.emax = m_emax; x.emin = m_emin;
        x.ethr = m_ethr; x.role = m_role; x.lowe = m_lowe; x.tx = m_tx;
        sb.push_back(x);
    endtask

    task automatic step();
        exp_t x;
        model_step();
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_val("myNodeID", 32'(myNodeID), 32'h000C);
        check_val("phase", 32'(phase), 32'(x.phase));
        check_val("hopsFromSink", 32'(hopsFromSink), 32'(x.hops));
        check_val("myQValue", 32'(myQValue), 32'(x.q));
        check_val("eMax", 32'(eMax), 32'(x.emax));
        check_val("eMin", 32'(eMin), 32'(x.emin));
        check_val("eThr", 32'(eThr), 32'(x.ethr));
        check_val("role", 32'(role), 32'(x.role));
        check_val("low_E", 32'(low_E), 32'(x.lowe));
        check_val("tx_en", 32'(tx_en), 32'(x.tx));
        pkt_if.en_MNI = 1'b0;
        q_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [2:0] t, input logic [15:0] f_hops, input logic [15:0] f_ethr,
                        input logic [15:0] f_ch, input logic [15:0] f_ts);
        pkt_if.en_MNI      = 1'b1;
        pkt_if.fPktType    = t;
        pkt_if.hops        = f_hops;
        pkt_if.e_max       = 16'd900;
        pkt_if.e_min       = 16'd100;
        pkt_if.e_threshold = f_ethr;
        pkt_if.ch_ID       = f_ch;
        pkt_if.timeslot    = f_ts;
        step();
    endtask

    initial begin
        rst = 1'b1; energy = 16'd250; q_in = 16'd0; q_valid = 1'b0;
        pkt_if.en_MNI = 1'b0; pkt_if.fPktType = 3'd0; pkt_if.hops = 16'd0;
        pkt_if.e_max = 16'd0; pkt_if.e_min = 16'd0; pkt_if.e_threshold = 16'd0;
        pkt_if.ch_ID = 16'd0; pkt_if.timeslot = 16'd0;
        idle(2);
        rst = 1'b0;
        idle(1);

        // HB lock, smaller/larger hops, energy hysteresis sequence
        send(3'b000, 16'd3, 16'd200, 16'd0, 16'd0);
        idle(1);
        send(3'b000, 16'd5, 16'd50, 16'd0, 16'd0);
        energy = 16'd250; step();
        energy = 16'd199; step();
        energy = 16'd220; step();
        energy = 16'd232; step();

        // CH role set/clear, HB hops update, unknown packet type
        q_in = 16'h1234; q_valid = 1'b1;
        send(3'b001, 16'd0, 16'd0, 16'h000C, 16'd0);
        send(3'b001, 16'd0, 16'd0, 16'h0007, 16'd0);
        send(3'b000, 16'd2, 16'd0, 16'd0, 16'd0);
        send(3'b010, 16'd1, 16'd0, 16'h000C, 16'd0);

        // TDMA window, ignored HB, relatch with out-of-range slot, DATA mid-slot
        send(3'b100, 16'd0, 16'd0, 16'd0, 16'd2);
        idle(20);
        send(3'b000, 16'd1, 16'd0, 16'd0, 16'd0);
        send(3'b100, 16'd0, 16'd0, 16'd0, 16'd5);
        idle(5);
        send(3'b101, 16'd0, 16'd0, 16'd0, 16'd0);
        idle(2);

        // lock timeout in LOCKED, CH on the timeout cycle, timeout in CLUSTERED
        send(3'b000, 16'd4, 16'd200, 16'd0, 16'd0);
        idle(10);
        send(3'b000, 16'd4, 16'd200, 16'd0, 16'd0);
        idle(7);
        send(3'b001, 16'd0, 16'd0, 16'h000C, 16'd0);
        idle(9);

        // reset while transmitting in SCHEDULED
        send(3'b000, 16'd6, 16'd200, 16'd0, 16'd0);
        send(3'b001, 16'd0, 16'd0, 16'h000C, 16'd0);
        q_in = 16'hBEEF; q_valid = 1'b1; energy = 16'd10;
        send(3'b100, 16'd0, 16'd0, 16'd0, 16'd0);
        idle(1);
        rst = 1'b1; step();
        rst = 1'b0; idle(1);

        // saturating hysteresis threshold near all-ones
        send(3'b000, 16'd1, 16'd65530, 16'd0, 16'd0);
        energy = 16'd65000; step();
        energy = 16'd65534; step();
        energy = 16'd65535; step();
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
